// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants and the scan controller state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2,
    ST_EMIT   = 2'd3
  } scan_state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_scan_ctrl.sv
// Drains the ps2_keyboard FIFO one byte at a time, folds E0/F0 prefixes into
// key events, tracks the held key and latches FIFO overflow.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int SUPPRESS_REPEAT = 1,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             fifo_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_release,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  scan_state_e state;
  logic [7:0]  byte_r;
  logic        ext_flag;
  logic        brk_flag;
  logic        held_ext;

  logic byte_is_ext;
  logic byte_is_brk;
  logic held_match;
  logic repeat_make;

  assign byte_is_ext = (byte_r == PS2_PFX_EXT);
  assign byte_is_brk = (byte_r == PS2_PFX_BRK);
  assign held_match  = (byte_r == held_code) && (ext_flag == held_ext);
  // A repeat only counts as one while the key is actually held.
  assign repeat_make = (SUPPRESS_REPEAT != 0) && key_down && held_match;

  // NOTE: every register here, datapath included, is reset; there is no
  // memory array, so clearing the lot is cheap and keeps X out of the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      byte_r          <= '0;
      ext_flag        <= 1'b0;
      brk_flag        <= 1'b0;
      held_ext        <= 1'b0;
      fifo_nextdata_n <= 1'b1;
      evt_valid       <= 1'b0;
      evt_code        <= '0;
      evt_ext         <= 1'b0;
      evt_release     <= 1'b0;
      key_down        <= 1'b0;
      held_code       <= '0;
      press_count     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // decision below sees the values from before this edge.
      unique case (state)
        ST_IDLE: begin
          if (fifo_ready) begin
            byte_r          <= fifo_data;
            fifo_nextdata_n <= 1'b0;
            state           <= ST_POP;
          end
        end

        // The pop strobe is low for this cycle only; DECODE gives the FIFO
        // one more cycle to refresh fifo_ready before IDLE looks again.
        ST_POP: begin
          fifo_nextdata_n <= 1'b1;
          state           <= ST_DECODE;
        end

        ST_DECODE: begin
          state <= ST_IDLE;
          if (byte_is_ext) begin
            ext_flag <= 1'b1;
          end else if (byte_is_brk) begin
            brk_flag <= 1'b1;
          end else begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            if (brk_flag) begin
              if (held_match) begin
                key_down  <= 1'b0;
                held_code <= '0;
              end
              evt_code    <= byte_r;
              evt_ext     <= ext_flag;
              evt_release <= 1'b1;
              evt_valid   <= 1'b1;
              state       <= ST_EMIT;
            end else if (!repeat_make) begin
              key_down    <= 1'b1;
              held_code   <= byte_r;
              held_ext    <= ext_flag;
              press_count <= press_count + CNT_W'(1);
              evt_code    <= byte_r;
              evt_ext     <= ext_flag;
              evt_release <= 1'b0;
              evt_valid   <= 1'b1;
              state       <= ST_EMIT;
            end
          end
        end

        ST_EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Overflow set takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (fifo_overflow) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a byte-stream reference model queues the
// expected events, a monitor checks them on each accepted handshake.
module tb_ps2_scan_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       fifo_data;
  logic             fifo_ready;
  logic             fifo_overflow;
  logic             fifo_nextdata_n;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_release;
  logic             key_down;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] press_count;
  logic             ovf_sticky;
  logic             ovf_clr;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.SUPPRESS_REPEAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .fifo_data(fifo_data), .fifo_ready(fifo_ready), .fifo_overflow(fifo_overflow),
    .fifo_nextdata_n(fifo_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_release(evt_release),
    .key_down(key_down), .held_code(held_code), .press_count(press_count),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       down;
    logic [7:0] held;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         bytes_sent = 0;
  int         pops = 0;
  int         low_run = 0;
  bit         rand_gate = 1'b0;
  bit         rand_ready = 1'b0;

  // Reference model: held-key bookkeeping expressed directly on the byte stream.
  bit         m_ext, m_brk, m_down, m_hext;
  logic [7:0] m_held;
  logic [7:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_down = 0; m_hext = 0; m_held = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    bit   emit;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      emit = 1;
      if (m_brk) begin
        if (b == m_held && m_ext == m_hext) begin
          m_down = 0;
          m_held = 8'h00;
        end
      end else if (m_down && b == m_held && m_ext == m_hext) begin
        emit = 0;
      end else begin
        m_down = 1; m_held = b; m_hext = m_ext; m_cnt = m_cnt + 8'd1;
      end
      if (emit) begin
        e.code = b; e.ext = m_ext; e.rel = m_brk;
        e.down = m_down; e.held = m_held; e.cnt = m_cnt;
        exp_q.push_back(e);
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    bytes_sent++;
    model_byte(b);
  endtask

  // Bench-side FIFO: pops on a low strobe, optionally hides its data at random.
  always @(negedge clk) begin
    if (fifo_nextdata_n === 1'b0) begin
      low_run++;
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (low_run > 1) check("nextdata_n_single_cycle", low_run, 1);
    end else begin
      low_run = 0;
    end
    fifo_ready = (fifo_q.size() > 0) && (rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 evt_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: compares every accepted event against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got code %0h ext %0b rel %0b, expected no event",
                 evt_code, evt_ext, evt_release);
      end else begin
        e = exp_q.pop_front();
        check("evt_code", evt_code, e.code);
        check("evt_ext", evt_ext, e.ext);
        check("evt_release", evt_release, e.rel);
        check("key_down", key_down, e.down);
        check("held_code", held_code, e.held);
        check("press_count", press_count, e.cnt);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nextdata_n"}, fifo_nextdata_n, 1);
    check({tag, "_evt_valid"}, evt_valid, 0);
    check({tag, "_evt_code"}, evt_code, 0);
    check({tag, "_evt_ext"}, evt_ext, 0);
    check({tag, "_evt_release"}, evt_release, 0);
    check({tag, "_key_down"}, key_down, 0);
    check({tag, "_held_code"}, held_code, 0);
    check({tag, "_press_count"}, press_count, 0);
    check({tag, "_ovf_sticky"}, ovf_sticky, 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int t = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && t < budget) begin
      @(posedge clk);
      t++;
    end
    check({tag, "_drained"}, (fifo_q.size() == 0 && exp_q.size() == 0), 1);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_final_key_down"}, key_down, m_down);
    check({tag, "_final_held_code"}, held_code, m_held);
    check({tag, "_final_press_count"}, press_count, m_cnt);
    check({tag, "_pops"}, pops, bytes_sent);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] codes[5];
    codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h75; codes[3] = 8'h23; codes[4] = 8'h1B;

    rst = 1; fifo_overflow = 0; ovf_clr = 0; evt_ready = 1;
    fifo_ready = 0; fifo_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;

    // Single make: latency from FIFO presentation to evt_valid.
    send(8'h1C);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!evt_valid && n < 20);
    check("make_latency", n, 3);
    drain("single_make", 200);

    // Typematic repeats then break.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain("repeat_break", 400);

    // Extended make and extended break.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain("extended", 400);

    // Backpressure: event held while the next byte waits in the FIFO.
    evt_ready = 0;
    send(8'h1C); send(8'h32);
    n = 0;
    while (!evt_valid && n < 50) begin
      @(negedge clk); n++;
    end
    check("bp_valid_seen", evt_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid_stable", evt_valid, 1);
      check("bp_code_stable", evt_code, 8'h1C);
      check("bp_no_pop", fifo_nextdata_n, 1);
    end
    check("bp_fifo_holds_32", fifo_q.size(), 1);
    @(posedge clk); #1;
    evt_ready = 1;
    drain("backpressure", 400);

    // Reset right after a popped F0 discards the break prefix.
    send(8'hF0);
    n = 0;
    while (fifo_nextdata_n !== 1'b0 && n < 50) begin
      @(negedge clk); n++;
    end
    check("rst_f0_popped", fifo_nextdata_n, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_reset_outputs("midrst");
    model_reset();
    exp_q.delete();
    send(8'h1C);
    drain("after_reset", 200);

    // Overflow latch: set, set-beats-clear, lone clear.
    fifo_overflow = 1;
    @(posedge clk); #1;
    fifo_overflow = 0;
    check("ovf_set", ovf_sticky, 1);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_persist", ovf_sticky, 1);
    fifo_overflow = 1; ovf_clr = 1;
    @(posedge clk); #1;
    fifo_overflow = 0; ovf_clr = 0;
    check("ovf_set_wins", ovf_sticky, 1);
    ovf_clr = 1;
    @(posedge clk); #1;
    ovf_clr = 0;
    check("ovf_clear", ovf_sticky, 0);

    // Random scancode streams with random FIFO gaps and consumer stalls.
    rand_gate = 1; rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      int sel = $urandom_range(0, 11);
      if (sel < 3) send(8'hE0);
      if (sel == 3) send(8'hE0);
      if (sel >= 4 && sel < 8) send(8'hF0);
      if (sel == 8) send(8'hF0);
      send(codes[$urandom_range(0, 4)]);
    end
    drain("random", 60000);
    rand_ready = 0;
    @(posedge clk); #2;
    evt_ready = 1;
    rand_gate = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
